// File: rtl/decode_resp_collector.sv
// ============================================================================
//  Module      : decode_resp_collector
//  Description : Return-path companion to the chip-select decoder. Captures
//                the target selected by one initiator request, waits for that
//                target's acknowledge (or a timeout) and hands the read data
//                or an error back over a valid/ready handshake. Flags any
//                acknowledge that does not belong to the outstanding request.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_resp_collector #(
  parameter int DW  = 32,  // read data width
  parameter int TMO = 16,  // WAIT cycles before timeout (2..255)
  parameter int CW  = 8    // timeout counter width, 2^CW > TMO
) (
  input  logic          clk,
  input  logic          rst,
  // initiator request side
  input  logic          req,
  input  logic [1:0]    addr,
  output logic          req_ready,
  // target bank
  input  logic          ce0_ack,
  input  logic [DW-1:0] ce0_rdata,
  input  logic          ce1_ack,
  input  logic [DW-1:0] ce1_rdata,
  input  logic          cs_ack,
  input  logic [DW-1:0] cs_rdata,
  // initiator response side
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_data,
  output logic          resp_err,
  output logic          stray_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Counter value seen in the last WAIT cycle before the timeout fires.
  localparam logic [CW-1:0] c_tmo_last = CW'(TMO - 1);

  // One-hot selection bit positions.
  localparam int c_ce0 = 0;
  localparam int c_ce1 = 1;
  localparam int c_cs  = 2;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_sel;
  logic [2:0]      w_sel_dec;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_data;
  logic            r_err;
  logic            r_stray;

  logic [2:0]      w_acks;
  logic            w_sel_ack;
  logic [DW-1:0]   w_sel_rdata;
  logic            w_timeout;
  logic            w_accept;
  logic            w_resp_hs;
  logic            w_stray_now;

  assign w_acks    = {cs_ack, ce1_ack, ce0_ack};
  assign w_sel_ack = |(w_acks & r_sel);
  assign w_timeout = (r_cnt == c_tmo_last);
  assign w_accept  = (r_state == ST_IDLE) && req;
  assign w_resp_hs = (r_state == ST_RESP) && resp_ready;

  // Address-to-target map; must stay identical to the forward decoder.
  always_comb begin
    w_sel_dec = 3'b000;
    case (addr)
      2'b10:   w_sel_dec[c_ce0] = 1'b1;
      2'b11:   w_sel_dec[c_ce1] = 1'b1;
      default: w_sel_dec[c_cs]  = 1'b1;
    endcase
  end

  // AND-OR mux of the read data using the one-hot selection.
  always_comb begin
    w_sel_rdata = ({DW{r_sel[c_ce0]}} & ce0_rdata)
                | ({DW{r_sel[c_ce1]}} & ce1_rdata)
                | ({DW{r_sel[c_cs]}}  & cs_rdata);
  end

  // An ack is stray unless it comes from the selected target while waiting.
  always_comb begin
    if (r_state == ST_WAIT) begin
      w_stray_now = |(w_acks & ~r_sel);
    end else begin
      w_stray_now = |w_acks;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; the selected ack takes priority over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_sel_ack || w_timeout) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Selection capture and timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel <= 3'b000;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_sel <= w_sel_dec;
      r_cnt <= '0;
    end else if (r_state == ST_WAIT) begin
      if (!w_sel_ack && !w_timeout) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else if (w_resp_hs) begin
      r_sel <= 3'b000;
    end
  end

  // Response payload, loaded once on leaving WAIT and held through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_err  <= 1'b0;
    end else if (r_state == ST_WAIT) begin
      if (w_sel_ack) begin
        r_data <= w_sel_rdata;
        r_err  <= 1'b0;
      end else if (w_timeout) begin
        r_data <= '0;
        r_err  <= 1'b1;
      end
    end
  end

  // One-cycle registered stray-ack flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stray <= 1'b0;
    end else begin
      r_stray <= w_stray_now;
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_data  = r_data;
  assign resp_err   = r_err;
  assign stray_ack  = r_stray;

endmodule

`default_nettype wire

// File: tb/tb_decode_resp_collector.sv
// ============================================================================
//  Module      : tb_decode_resp_collector
//  Description : Directed bench for decode_resp_collector with a transaction
//                level reference model and a per-cycle output compare.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_resp_collector;

  localparam int DW  = 32;
  localparam int TMO = 16;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req = 1'b0;
  logic [1:0]    addr = 2'b00;
  logic          req_ready;
  logic          ce0_ack = 1'b0;
  logic [DW-1:0] ce0_rdata = '0;
  logic          ce1_ack = 1'b0;
  logic [DW-1:0] ce1_rdata = '0;
  logic          cs_ack = 1'b0;
  logic [DW-1:0] cs_rdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic          stray_ack;

  int n_vec = 0;
  int n_err = 0;

  decode_resp_collector #(.DW(DW), .TMO(TMO), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .addr       (addr),
    .req_ready  (req_ready),
    .ce0_ack    (ce0_ack),
    .ce0_rdata  (ce0_rdata),
    .ce1_ack    (ce1_ack),
    .ce1_rdata  (ce1_rdata),
    .cs_ack     (cs_ack),
    .cs_rdata   (cs_rdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .stray_ack  (stray_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: transaction phase (0 idle, 1 waiting, 2 responding),
  // target index (0 ce0, 1 ce1, 2 cs) and number of unanswered wait cycles.
  // ------------------------------------------------------------------
  int            m_phase  = 0;
  int            m_tgt    = 0;
  int            m_waited = 0;
  logic [DW-1:0] m_data   = '0;
  logic          m_err    = 1'b0;
  logic          m_stray  = 1'b0;
  logic [2:0]    m_acks;
  logic [DW-1:0] m_rd [3];

  always_comb begin
    m_acks   = {cs_ack, ce1_ack, ce0_ack};
    m_rd[0]  = ce0_rdata;
    m_rd[1]  = ce1_rdata;
    m_rd[2]  = cs_rdata;
  end

  function automatic int target_of(input logic [1:0] a);
    if (a == 2'b10) return 0;
    if (a == 2'b11) return 1;
    return 2;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase  <= 0;
      m_waited <= 0;
      m_data   <= '0;
      m_err    <= 1'b0;
      m_stray  <= 1'b0;
    end else begin
      if (m_phase == 1) m_stray <= |(m_acks & ~(3'b001 << m_tgt));
      else              m_stray <= |m_acks;
      if (m_phase == 0) begin
        if (req) begin
          m_tgt    <= target_of(addr);
          m_waited <= 0;
          m_phase  <= 1;
        end
      end else if (m_phase == 1) begin
        if (m_acks[m_tgt]) begin
          m_data  <= m_rd[m_tgt];
          m_err   <= 1'b0;
          m_phase <= 2;
        end else if (m_waited + 1 == TMO) begin
          m_data  <= '0;
          m_err   <= 1'b1;
          m_phase <= 2;
        end else begin
          m_waited <= m_waited + 1;
        end
      end else begin
        if (resp_ready) m_phase <= 0;
      end
    end
  end

  // Per-cycle compare, mid-cycle; payload only while a response is offered.
  always @(negedge clk) begin
    chk("m_req_ready",  {31'd0, req_ready},  {31'd0, m_phase == 0});
    chk("m_resp_valid", {31'd0, resp_valid}, {31'd0, m_phase == 2});
    chk("m_stray_ack",  {31'd0, stray_ack},  {31'd0, m_stray});
    if (m_phase == 2) begin
      chk("m_resp_data", resp_data, m_data);
      chk("m_resp_err",  {31'd0, resp_err}, {31'd0, m_err});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b1;
    step();
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk1("rst_resp_err", resp_err, 1'b0);
    chk1("rst_stray", stray_ack, 1'b0);
    step();
    rst = 1'b0;
    step();

    // Basic cs read, ack in cycle 3.
    req = 1'b1; addr = 2'b01; resp_ready = 1'b1;        // cycle 0
    step(); req = 1'b0;                                 // cycle 1
    step();                                             // cycle 2
    step(); cs_ack = 1'b1; cs_rdata = 32'hDEAD_BEEF;    // cycle 3
    chk1("basic_no_valid_c3", resp_valid, 1'b0);
    step(); cs_ack = 1'b0;                              // cycle 4
    chk1("basic_valid", resp_valid, 1'b1);
    chk("basic_data", resp_data, 32'hDEAD_BEEF);
    chk1("basic_err", resp_err, 1'b0);
    step();                                             // cycle 5
    chk1("basic_ready_back", req_ready, 1'b1);

    // Selection: ce0 selected, ce1 ack is stray.
    req = 1'b1; addr = 2'b10;                           // cycle 0
    step(); req = 1'b0; ce1_ack = 1'b1; ce1_rdata = 32'h1111_1111;   // cycle 1
    step(); ce1_ack = 1'b0; ce0_ack = 1'b1; ce0_rdata = 32'h2222_2222; // cycle 2
    chk1("sel_stray", stray_ack, 1'b1);
    chk1("sel_still_wait", resp_valid, 1'b0);
    step(); ce0_ack = 1'b0;                             // cycle 3
    chk("sel_data", resp_data, 32'h2222_2222);
    chk1("sel_no_stray", stray_ack, 1'b0);
    step();

    // Timeout with no ce1 ack.
    req = 1'b1; addr = 2'b11;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 1) req = 1'b0;
    end
    chk1("tmo_not_yet", resp_valid, 1'b0);              // cycle 16
    step();                                             // cycle 17
    chk1("tmo_valid", resp_valid, 1'b1);
    chk1("tmo_err", resp_err, 1'b1);
    chk("tmo_data", resp_data, 32'h0);
    step();

    // Ack in the last wait cycle wins over the timeout.
    req = 1'b1; addr = 2'b11;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 1) req = 1'b0;
    end
    ce1_ack = 1'b1; ce1_rdata = 32'h3333_3333;          // cycle 16
    step(); ce1_ack = 1'b0;                             // cycle 17
    chk1("win_valid", resp_valid, 1'b1);
    chk1("win_err", resp_err, 1'b0);
    chk("win_data", resp_data, 32'h3333_3333);
    step();

    // Backpressure for 10 cycles with ignored reqs and a stray cs ack.
    resp_ready = 1'b0;
    req = 1'b1; addr = 2'b00;
    step(); req = 1'b0; cs_ack = 1'b1; cs_rdata = 32'h4444_4444;
    step(); cs_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk1("bp_valid", resp_valid, 1'b1);
      chk("bp_data", resp_data, 32'h4444_4444);
      chk1("bp_err", resp_err, 1'b0);
      chk1("bp_req_ready", req_ready, 1'b0);
      if (i == 4) chk1("bp_stray", stray_ack, 1'b1);
      req  = (i % 2 == 0);
      addr = 2'b10;
      cs_ack = (i == 3);
      if (i == 3) cs_rdata = 32'h5555_5555;
      step();
    end
    req = 1'b0; cs_ack = 1'b0; resp_ready = 1'b1;
    chk("bp_data_end", resp_data, 32'h4444_4444);
    step();
    chk1("bp_released", req_ready, 1'b1);
    chk1("bp_valid_drop", resp_valid, 1'b0);

    // Reset in WAIT cycle 5.
    req = 1'b1; addr = 2'b10;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) req = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk1("arst_req_ready", req_ready, 1'b1);
    chk1("arst_valid", resp_valid, 1'b0);
    chk("arst_data", resp_data, 32'h0);
    chk1("arst_err", resp_err, 1'b0);
    chk1("arst_stray", stray_ack, 1'b0);
    step();
    rst = 1'b0; ce0_ack = 1'b1; ce0_rdata = 32'h7777_7777;
    step(); ce0_ack = 1'b0;
    chk1("late_stray", stray_ack, 1'b1);
    chk1("late_idle", req_ready, 1'b1);
    step();
    chk1("late_stray_end", stray_ack, 1'b0);
    req = 1'b1; addr = 2'b00;
    step(); req = 1'b0; cs_ack = 1'b1; cs_rdata = 32'h6666_6666;
    step(); cs_ack = 1'b0;
    chk1("post_rst_valid", resp_valid, 1'b1);
    chk("post_rst_data", resp_data, 32'h6666_6666);
    step();

    // Back-to-back ce0, ce1, cs with resp_ready high.
    for (int t = 0; t < 3; t++) begin
      logic [DW-1:0] d;
      d = 32'hA000_0000 + DW'(t);
      chk1("b2b_ready", req_ready, 1'b1);
      req = 1'b1;
      addr = (t == 0) ? 2'b10 : (t == 1) ? 2'b11 : 2'b00;
      step(); req = 1'b0;
      if (t == 0) begin ce0_ack = 1'b1; ce0_rdata = d; end
      if (t == 1) begin ce1_ack = 1'b1; ce1_rdata = d; end
      if (t == 2) begin cs_ack  = 1'b1; cs_rdata  = d; end
      step(); ce0_ack = 1'b0; ce1_ack = 1'b0; cs_ack = 1'b0;
      chk1("b2b_valid", resp_valid, 1'b1);
      chk("b2b_data", resp_data, d);
      chk1("b2b_stray", stray_ack, 1'b0);
      step();
    end
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
